link_partner_dll_rsp: RTL and testbench
=======================================

LINK_PARTNER_DLL_RSP -- requirements
Module: link_partner_dll_rsp

Interface
REQ-001 SHALL have parameter PIPE_DATA_WIDTH, default 256, PIPE beat width; only 256 is supported.
REQ-002 SHALL have parameter CREDIT_DEPTH, default 12, width of credit and sequence fields.
REQ-003 SHALL have parameters INIT_PH=32, INIT_PD=256, INIT_NH=32, INIT_CH=0, INIT_CD=0, the advertised initial credits; 0 means infinite.
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 pipe_rxdata_i  input  256  beat received from the DUT transmitter.
REQ-007 pipe_rxvalid_i  input  1  rxdata qualifier.
REQ-008 pipe_txdata_o  output  256  DLLP beat sent to the DUT receiver.
REQ-009 pipe_txvalid_o  output  1  txdata qualifier.
REQ-010 next_rcv_seq_o  output  12  expected TLP sequence number.
REQ-011 err_cnt_o  output  8  framing and sequence error count, saturating at 255.

Function
REQ-012 Beat format SHALL use type[255:248]: 8'h01 = TLP start, 8'h02 = DLLP; any other value on a start-position beat is a framing error.
REQ-013 A TLP start beat SHALL carry seq[247:236], len[235:232] (total beats 1..8, 0 treated as 1) and class[231:230] (0 = P, 1 = NP, 2 = Cpl, 3 = error).
REQ-014 A DLLP SHALL carry subtype[247:240] (00 Ack, 10 Nak, 80/90/A0 UpdateFC P/NP/Cpl), seq[235:224], hdr credit[223:212] and data credit[211:200]; all other bits SHALL be 0.
REQ-015 The RX FSM SHALL have states IDLE, DATA and DROP, with a beat counter.
- IDLE + valid start beat, seq == next_rcv_seq, class != 3 -> accept.
  - len == 1: frame completes this cycle.
  - otherwise: go to DATA.
- IDLE + start beat with wrong seq or class 3 -> DROP for len-1 beats (IDLE directly if len == 1), then treat as bad.
REQ-016 Beats with rxvalid=0 SHALL not advance the beat counter; gaps are allowed mid-frame.
REQ-017 A start beat received in DATA or DROP SHALL abort the current frame (no Ack, err_cnt +1) and be processed as a new start in the same cycle.
REQ-018 A non-start valid beat received in IDLE SHALL be discarded with err_cnt +1.
REQ-019 On a good frame completing:
- next_rcv_seq += 1 modulo 4096;
- the Ack-pending flag is set and ack_seq = received seq (coalescing: the latest seq overwrites);
- nak_sched is cleared.
REQ-020 On a bad frame completing:
- err_cnt +1;
- if nak_sched == 0, set Nak-pending with seq = next_rcv_seq-1 (mod 4096) and set nak_sched;
- if nak_sched == 1, send no further Nak.
REQ-021 Credit return: each good frame SHALL schedule UpdateFC for its class, with hdr limit += 1 and data limit += 2*(len-1) for P and Cpl, modulo 4096.
- An infinite (0) field SHALL stay 0.
- NP data is always 0.
REQ-022 The TX FSM SHALL have states INIT0, INIT1, INIT2 and RUN.
- INIT0/1/2 send UpdateFC P, NP and Cpl with the INIT_* values on 3 consecutive cycles, then go to RUN.
- RX processing is active during INIT; pending DLLPs wait for RUN.
REQ-023 In RUN, at most one DLLP SHALL be sent per cycle.
- Priority: Nak > Ack > UpdateFC P > NP > Cpl.
- A sent item clears its pending flag, unless it is re-set in the same cycle, in which case it stays pending with the new value.
REQ-024 TX outputs SHALL be registered: an event completing at cycle N is visible on txvalid at N+1 at the earliest.
REQ-025 When nothing is sent, pipe_txvalid_o SHALL be 0 and pipe_txdata_o SHALL be 0.
REQ-026 Credit limits and next_rcv_seq SHALL wrap at 4096 with no saturation; err_cnt SHALL saturate at 255.

Reset
REQ-027 While rst=1, the block SHALL hold:
- RX FSM = IDLE, TX FSM = INIT0;
- next_rcv_seq = 0, err_cnt = 0;
- all pending flags and nak_sched = 0;
- credit limits = INIT_*;
- pipe_txvalid_o = 0, pipe_txdata_o = 0.
REQ-028 Reset asserted mid-frame SHALL discard the frame with no Ack or Nak; the cycle after release SHALL emit InitFC P.

Verification
REQ-029 Release reset, no input -> txvalid high for exactly 3 cycles: subtypes 80/90/A0 with hdr 32/32/0 and data 256/0/0, then txvalid=0.
REQ-030 After init, 4-beat P TLP seq 0 -> Ack seq 0 on the next cycle, then UpdateFC P hdr 33 / data 262; next_rcv_seq_o = 1.
REQ-031 Two back-to-back 1-beat TLPs seq 0 then 1 -> single Ack seq 1 (coalesced), next_rcv_seq_o = 2.
REQ-032 TLP seq 5 while expecting 0 -> Nak seq 4095, err_cnt_o = 1; a second bad TLP -> no Nak, err_cnt_o = 2; good seq 0 -> Ack 0.
REQ-033 Start beat at beat 2 of a 4-beat frame -> first frame aborted, err_cnt_o = 1, new frame processed normally.
REQ-034 next_rcv_seq at 4095 + good TLP seq 4095 -> Ack 4095, next_rcv_seq_o = 0.

Source files
------------

// File: rtl/link_partner_dll_rsp_if.sv
// link_partner_dll_rsp_if: PIPE beat bundle between the DUT link layer and its link partner
// rx: beats from the DUT transmitter (pipe_rxdata_i/pipe_rxvalid_i)
// tx: DLLP beats to the DUT receiver (pipe_txdata_o/pipe_txvalid_o)
// master drives rx and observes tx; slave (the link partner) does the opposite.
interface link_partner_dll_rsp_if #(
  parameter int PIPE_DATA_WIDTH = 256
);
  logic [PIPE_DATA_WIDTH-1:0] pipe_rxdata_i;
  logic                       pipe_rxvalid_i;
  logic [PIPE_DATA_WIDTH-1:0] pipe_txdata_o;
  logic                       pipe_txvalid_o;
  modport master (output pipe_rxdata_i, pipe_rxvalid_i, input pipe_txdata_o, pipe_txvalid_o);
  modport slave (input pipe_rxdata_i, pipe_rxvalid_i, output pipe_txdata_o, pipe_txvalid_o);
endinterface

// File: rtl/link_partner_dll_rsp.sv
// link_partner_dll_rsp: link-partner data link layer that checks received TLPs and returns Ack/Nak/UpdateFC DLLPs
// clk, rst        : rising-edge clock, synchronous active-high reset
// pipe (slave)    : rx beats from the DUT transmitter, registered DLLP beats to the DUT receiver
// next_rcv_seq_o  : sequence number expected on the next TLP
// err_cnt_o       : framing/sequence error count, saturating at 255
module link_partner_dll_rsp #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int CREDIT_DEPTH    = 12,
  parameter int INIT_PH         = 32,
  parameter int INIT_PD         = 256,
  parameter int INIT_NH         = 32,
  parameter int INIT_CH         = 0,
  parameter int INIT_CD         = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  link_partner_dll_rsp_if.slave   pipe,
  output logic [CREDIT_DEPTH-1:0] next_rcv_seq_o,
  output logic [7:0]              err_cnt_o
);
  localparam int C = CREDIT_DEPTH;
  typedef enum logic [1:0] {IDLE, DATA, DROP} rx_t;
  typedef enum logic [1:0] {INIT0, INIT1, INIT2, RUN} tx_t;
  rx_t rx_state, rx_next;
  tx_t tx_state, tx_next;
  logic                       vld, start, in_frame, abort, stray, start_ok, last_mid;
  logic                       good_done, bad_done, set_nak;
  logic [7:0]                 typ;
  logic [C-1:0]               b_seq, f_seq, d_seq;
  logic [3:0]                 b_len, f_len, d_len, rem;
  logic [1:0]                 b_cls, f_cls, d_cls;
  logic [C-1:0]               next_seq, ack_seq, nak_seq, ph, pd, nh, ch, cd, dcr;
  logic [7:0]                 err;
  logic [1:0]                 inc;
  logic [8:0]                 err_sum;
  logic                       ack_pend, nak_pend, nak_sched;
  logic [2:0]                 fc_pend, fc_set, snd_fc;
  logic                       run, snd_nak, snd_ack, tx_any, txv;
  logic [PIPE_DATA_WIDTH-1:0] tx_word, txd;

  function automatic logic [PIPE_DATA_WIDTH-1:0] dllp(input logic [7:0] sub, input logic [C-1:0] seq, hdr, dat);
    dllp = '0;
    dllp[255:248] = 8'h02;
    dllp[247:240] = sub;
    dllp[235:224] = seq;
    dllp[223:212] = hdr;
    dllp[211:200] = dat;
  endfunction

  // a zero limit advertises infinite credit and never moves
  function automatic logic [C-1:0] bump(input logic [C-1:0] lim, input logic [C-1:0] add);
    bump = lim == '0 ? '0 : lim + add;
  endfunction

  assign vld      = pipe.pipe_rxvalid_i;
  assign typ      = pipe.pipe_rxdata_i[255:248];
  assign b_seq    = pipe.pipe_rxdata_i[247:236];
  assign b_len    = pipe.pipe_rxdata_i[235:232] == 4'd0 ? 4'd1 : pipe.pipe_rxdata_i[235:232];
  assign b_cls    = pipe.pipe_rxdata_i[231:230];
  assign in_frame = rx_state != IDLE;
  assign start    = vld && typ == 8'h01;
  assign abort    = start && in_frame;
  assign stray    = vld && !in_frame && typ != 8'h01 && typ != 8'h02;
  assign start_ok = b_seq == next_seq && b_cls != 2'd3;
  assign last_mid = vld && !start && in_frame && rem == 4'd1;
  // a start beat always opens a new frame, even if it aborts the current one
  assign good_done = start ? start_ok && b_len == 4'd1 : last_mid && rx_state == DATA;
  assign bad_done  = start ? !start_ok && b_len == 4'd1 : last_mid && rx_state == DROP;
  assign d_len     = start ? b_len : f_len;
  assign d_seq     = start ? b_seq : f_seq;
  assign d_cls     = start ? b_cls : f_cls;
  assign set_nak   = bad_done && !nak_sched;
  assign fc_set    = good_done ? 3'b001 << d_cls : 3'b000;
  assign dcr       = C'({d_len - 4'd1, 1'b0});
  assign inc       = 2'(abort) + 2'(stray) + 2'(bad_done);
  assign err_sum   = {1'b0, err} + {7'd0, inc};

  always_ff @(posedge clk)
    rx_state <= rst ? IDLE : rx_next;

  always_comb
    rx_next = start ? (b_len == 4'd1 ? IDLE : start_ok ? DATA : DROP) : last_mid ? IDLE : rx_state;

  always_ff @(posedge clk)
    if (start) begin
      f_seq <= b_seq;
      f_len <= b_len;
      f_cls <= b_cls;
      rem   <= b_len - 4'd1;
    end else if (vld && in_frame) rem <= rem - 4'd1;

  always_ff @(posedge clk)
    if (rst) begin
      next_seq  <= '0;
      err       <= '0;
      ack_pend  <= 1'b0;
      nak_pend  <= 1'b0;
      nak_sched <= 1'b0;
      fc_pend   <= '0;
      ack_seq   <= '0;
      nak_seq   <= '0;
      ph        <= C'(INIT_PH);
      pd        <= C'(INIT_PD);
      nh        <= C'(INIT_NH);
      ch        <= C'(INIT_CH);
      cd        <= C'(INIT_CD);
    end else begin
      next_seq  <= next_seq + C'(good_done);
      err       <= err_sum[8] ? 8'hff : err_sum[7:0];
      // a re-set in the same cycle as the send keeps the item pending with its new value
      ack_pend  <= good_done || (ack_pend && !snd_ack);
      ack_seq   <= good_done ? d_seq : ack_seq;
      nak_pend  <= set_nak || (nak_pend && !snd_nak);
      nak_seq   <= set_nak ? next_seq - C'(1) : nak_seq;
      nak_sched <= good_done ? 1'b0 : bad_done ? 1'b1 : nak_sched;
      fc_pend   <= fc_set | (fc_pend & ~snd_fc);
      ph        <= fc_set[0] ? bump(ph, C'(1)) : ph;
      pd        <= fc_set[0] ? bump(pd, dcr) : pd;
      nh        <= fc_set[1] ? bump(nh, C'(1)) : nh;
      ch        <= fc_set[2] ? bump(ch, C'(1)) : ch;
      cd        <= fc_set[2] ? bump(cd, dcr) : cd;
    end

  always_ff @(posedge clk)
    tx_state <= rst ? INIT0 : tx_next;

  always_comb
    tx_next = tx_state == INIT0 ? INIT1 : tx_state == INIT1 ? INIT2 : RUN;

  assign run       = tx_state == RUN;
  assign snd_nak   = run && nak_pend;
  assign snd_ack   = run && ack_pend && !nak_pend;
  assign snd_fc[0] = run && fc_pend[0] && !nak_pend && !ack_pend;
  assign snd_fc[1] = run && fc_pend[1] && !nak_pend && !ack_pend && !fc_pend[0];
  assign snd_fc[2] = run && fc_pend[2] && !nak_pend && !ack_pend && fc_pend[1:0] == 2'b00;
  assign tx_any    = !run || nak_pend || ack_pend || |fc_pend;

  always_comb
    tx_word = tx_state == INIT0 ? dllp(8'h80, '0, C'(INIT_PH), C'(INIT_PD))
            : tx_state == INIT1 ? dllp(8'h90, '0, C'(INIT_NH), '0)
            : tx_state == INIT2 ? dllp(8'hA0, '0, C'(INIT_CH), C'(INIT_CD))
            : snd_nak   ? dllp(8'h10, nak_seq, '0, '0)
            : snd_ack   ? dllp(8'h00, ack_seq, '0, '0)
            : snd_fc[0] ? dllp(8'h80, '0, ph, pd)
            : snd_fc[1] ? dllp(8'h90, '0, nh, '0)
            : snd_fc[2] ? dllp(8'hA0, '0, ch, cd)
            : '0;

  always_ff @(posedge clk) begin
    txv <= !rst && tx_any;
    txd <= rst ? '0 : tx_word;
  end

  assign pipe.pipe_txdata_o  = txd;
  assign pipe.pipe_txvalid_o = txv;
  assign next_rcv_seq_o      = next_seq;
  assign err_cnt_o           = err;
endmodule

// File: tb/tb_link_partner_dll_rsp.sv
// tb_link_partner_dll_rsp: random + directed scoreboard bench for link_partner_dll_rsp
module tb_link_partner_dll_rsp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  link_partner_dll_rsp_if #(.PIPE_DATA_WIDTH(256)) bus();
  logic [11:0] next_rcv_seq;
  logic [7:0]  err_cnt;

  link_partner_dll_rsp dut (
    .clk(clk),
    .rst(rst),
    .pipe(bus),
    .next_rcv_seq_o(next_rcv_seq),
    .err_cnt_o(err_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_q[$];
  logic [255:0] exp_w;

  int         init_h[3]   = '{32, 32, 0};
  int         init_d[3]   = '{256, 0, 0};
  logic [7:0] init_sub[3] = '{8'h80, 8'h90, 8'hA0};

  // reference state: items 0 Nak, 1 Ack, 2 FC P, 3 FC NP, 4 FC Cpl in priority order
  logic [11:0] m_seq;
  int          m_err;
  bit          m_sched;
  int          tx_phase;
  bit          pend[5];
  logic [11:0] pval[5];
  int          lim_h[3], lim_d[3];
  bit          busy, f_ok;
  logic [11:0] f_seq;
  int          f_len, f_cls, left;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endfunction

  function automatic logic [255:0] dllp(logic [7:0] sub, logic [11:0] s, int h, int d);
    logic [255:0] w = '0;
    w[255:248] = 8'h02;
    w[247:240] = sub;
    w[235:224] = s;
    w[223:212] = h[11:0];
    w[211:200] = d[11:0];
    return w;
  endfunction

  function automatic logic [255:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model_reset();
    m_seq = 0; m_err = 0; m_sched = 0; tx_phase = 0; busy = 0;
    for (int k = 0; k < 5; k++) begin pend[k] = 0; pval[k] = 0; end
    lim_h = '{32, 32, 0};
    lim_d = '{256, 0, 0};
  endfunction

  function automatic void bump_err();
    if (m_err < 255) m_err++;
  endfunction

  function automatic logic [255:0] item_word(int k);
    case (k)
      0: return dllp(8'h10, pval[0], 0, 0);
      1: return dllp(8'h00, pval[1], 0, 0);
      2: return dllp(8'h80, 0, lim_h[0], lim_d[0]);
      3: return dllp(8'h90, 0, lim_h[1], 0);
      default: return dllp(8'hA0, 0, lim_h[2], lim_d[2]);
    endcase
  endfunction

  function automatic void finish_frame(bit ok, logic [11:0] s, int l, int c);
    if (ok) begin
      m_seq = m_seq + 1;
      pend[1] = 1; pval[1] = s; m_sched = 0;
      if (lim_h[c] != 0) lim_h[c] = (lim_h[c] + 1) % 4096;
      if (c != 1 && lim_d[c] != 0) lim_d[c] = (lim_d[c] + 2 * (l - 1)) % 4096;
      pend[2 + c] = 1;
    end else begin
      bump_err();
      if (!m_sched) begin pend[0] = 1; pval[0] = m_seq - 1; m_sched = 1; end
    end
  endfunction

  // one clock of the reference: DLLP chosen from state before the edge, then the received beat
  function automatic void model_step(bit v, logic [255:0] d);
    int c, l;
    logic [11:0] s;
    bit ok;
    if (rst) begin model_reset(); return; end
    if (tx_phase < 3) begin
      exp_q.push_back(dllp(init_sub[tx_phase], 0, init_h[tx_phase], init_d[tx_phase]));
      tx_phase++;
    end else
      for (int k = 0; k < 5; k++)
        if (pend[k]) begin exp_q.push_back(item_word(k)); pend[k] = 0; break; end
    if (!v) return;
    if (d[255:248] == 8'h01) begin
      if (busy) bump_err();
      busy = 0;
      s = d[247:236];
      l = d[235:232] == 4'd0 ? 1 : int'(d[235:232]);
      c = int'(d[231:230]);
      ok = s == m_seq && c != 3;
      if (l == 1) finish_frame(ok, s, l, c);
      else begin busy = 1; f_ok = ok; f_seq = s; f_len = l; f_cls = c; left = l - 1; end
    end else if (busy) begin
      left--;
      if (left == 0) begin busy = 0; finish_frame(f_ok, f_seq, f_len, f_cls); end
    end else if (d[255:248] != 8'h02) bump_err();
  endfunction

  task automatic cyc(input bit v, input logic [255:0] d);
    bus.pipe_rxvalid_i = v;
    bus.pipe_rxdata_i  = d;
    @(posedge clk);
    #1;
    model_step(v, d);
    chk("next_rcv_seq", int'(next_rcv_seq), int'(m_seq));
    chk("err_cnt", int'(err_cnt), m_err);
  endtask

  task automatic send_tlp(input logic [11:0] s, input int l, input int c, input int nbeats, input int gap);
    logic [255:0] w;
    for (int i = 0; i < nbeats; i++) begin
      while (gap != 0 && $urandom_range(99) < gap) cyc(1'b0, rnd());
      w = rnd();
      if (i == 0) begin
        w[255:248] = 8'h01; w[247:236] = s; w[235:232] = 4'(l); w[231:230] = 2'(c);
      end else w[255:248] = 8'h00;
      cyc(1'b1, w);
    end
  endtask

  task automatic stray_beat();
    logic [255:0] w = rnd();
    w[255:248] = 8'(3 + $urandom_range(250));
    cyc(1'b1, w);
  endtask

  task automatic drain();
    int n = 0;
    bit any = 1;
    while (any && n < 64) begin
      any = tx_phase < 3;
      for (int k = 0; k < 5; k++) any |= pend[k];
      if (any) begin cyc(1'b0, '0); n++; end
    end
    if (n >= 64) begin errors++; $display("FAIL drain_timeout got=%0d exp=<64", n); end
    repeat (2) cyc(1'b0, '0);
    chk("tx_queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cyc(1'b0, '0);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    checks++;
    if (bus.pipe_txvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected got=%h exp=none", bus.pipe_txdata_o);
      end else begin
        exp_w = exp_q.pop_front();
        if (bus.pipe_txdata_o !== exp_w) begin
          errors++;
          $display("FAIL tx_word got=%h exp=%h", bus.pipe_txdata_o, exp_w);
        end
      end
    end else if (bus.pipe_txvalid_o !== 1'b0 || bus.pipe_txdata_o !== '0) begin
      errors++;
      $display("FAIL tx_idle got=%b/%h exp=0/0", bus.pipe_txvalid_o, bus.pipe_txdata_o);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, l, n, c;
    logic [11:0] s;
    bus.pipe_rxvalid_i = 1'b0;
    bus.pipe_rxdata_i  = '0;
    model_reset();
    do_reset(3);
    repeat (6) cyc(1'b0, '0);
    drain();
    send_tlp(12'd0, 4, 0, 4, 20);
    drain();
    do_reset(2);
    send_tlp(12'd0, 1, 0, 1, 0);
    send_tlp(12'd1, 1, 0, 1, 0);
    drain();
    do_reset(2);
    repeat (4) cyc(1'b0, '0);
    send_tlp(12'd5, 1, 0, 1, 0);
    send_tlp(12'd7, 2, 1, 2, 0);
    send_tlp(12'd0, 1, 0, 1, 0);
    drain();
    send_tlp(12'd1, 4, 0, 2, 0);
    send_tlp(12'd1, 4, 2, 4, 0);
    drain();
    send_tlp(m_seq, 4, 0, 2, 0);
    do_reset(2);
    drain();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(99);
      l = $urandom_range(8);
      n = l == 0 ? 1 : l;
      c = $urandom_range(9) == 0 ? 3 : $urandom_range(2);
      s = $urandom_range(7) == 0 ? 12'($urandom) : m_seq;
      if (r < 6) stray_beat();
      else if (r < 12 && n > 1) send_tlp(s, l, c, $urandom_range(n - 1, 1), 15);
      else send_tlp(s, l, c, n, 15);
      if ($urandom_range(3) == 0) cyc(1'b0, rnd());
    end
    drain();
    repeat (4097) send_tlp(m_seq, $urandom_range(2, 1), $urandom_range(2), 1, 0);
    drain();
    repeat (260) stray_beat();
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
